// File: rtl/arb_pkg.sv
// Shared types and helpers for the quantum-weighted round-robin arbiter.
package arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_SERVE = 1'b1
   } arb_state_t;

   // Rotating successor of idx among n requesters (n need not be a power of 2).
   function automatic int unsigned rr_inc(input int unsigned idx, input int unsigned n);
      return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder: first eligible index at or after ptr,
// wrapping from NUM_REQS-1 back to 0.
module rr_pick #(
   parameter  int NUM_REQS = 4,
   localparam int IDXW     = $clog2(NUM_REQS)
) (
   input  logic [NUM_REQS-1:0] eligible,
   input  logic [IDXW-1:0]     ptr,
   output logic                found,
   output logic [IDXW-1:0]     idx
);

   always_comb begin
      int          j;
      logic [IDXW-1:0] jj;
      found = 1'b0;
      idx   = '0;
      j     = 0;
      jj    = '0;
      // Walk offsets from farthest to nearest so the nearest eligible one wins last.
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQS) j = j - NUM_REQS;
         jj = IDXW'(j);
         if (eligible[jj]) begin
            found = 1'b1;
            idx   = jj;
         end
      end
   end

endmodule

// File: rtl/quantum_rr_arbiter.sv
// Quantum-weighted round-robin arbiter driving the pop vector of a FIFO bank.
// Build option ARB_DEFICIT_CARRY_EN carries unused credit of a drained burst forward.
module quantum_rr_arbiter
   import arb_pkg::*;
#(
   parameter  int NUM_REQS = 4,
   parameter  int QWID     = 4,
   localparam int IDXW     = $clog2(NUM_REQS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQS-1:0]      reqs,
   input  logic [NUM_REQS*QWID-1:0] quantums,
   output logic [NUM_REQS-1:0]      gnt,
   output logic                     gnt_vld,
   output logic [IDXW-1:0]          gnt_idx,
   output logic                     burst_done
);

`ifdef ARB_DEFICIT_CARRY_EN
   localparam int CW = QWID + 1;
`else
   localparam int CW = QWID;
`endif

   // Handshake: reqs[i] is the valid (FIFO non-empty); gnt[i] is the pop and is only
   // raised while reqs[i] is high in the same cycle, so a word moves when both are 1.

   arb_state_t          state_q, state_d;
   logic [IDXW-1:0]     ptr_q, ptr_d;
   logic [IDXW-1:0]     owner_q, owner_d;
   logic [CW-1:0]       credit_q, credit_d;
   logic                burst_done_q;
   logic                burst_end;

   logic [NUM_REQS-1:0] eligible;
   logic                pick_found;
   logic [IDXW-1:0]     pick_idx;
   logic [QWID-1:0]     q_pick;
   logic [CW-1:0]       start_credit;
   logic                owner_req;
   logic                gnt_on;

   for (genvar g = 0; g < NUM_REQS; g++) begin : g_elig
      assign eligible[g] = reqs[g] && (|quantums[g*QWID +: QWID]);
   end

   rr_pick #(.NUM_REQS(NUM_REQS)) u_pick (
      .eligible (eligible),
      .ptr      (ptr_q),
      .found    (pick_found),
      .idx      (pick_idx)
   );

   assign q_pick    = quantums[pick_idx*QWID +: QWID];
   assign owner_req = reqs[owner_q];
   assign gnt_on    = (state_q == ARB_SERVE) && owner_req && (credit_q != '0);

`ifdef ARB_DEFICIT_CARRY_EN
   logic [NUM_REQS-1:0][QWID:0] deficit_q, deficit_d;
   logic [QWID+1:0]             credit_sum;

   // Quantum plus carried deficit, saturating at the credit register's full scale.
   assign credit_sum   = {2'b00, q_pick} + {1'b0, deficit_q[pick_idx]};
   assign start_credit = credit_sum[QWID+1] ? '1 : credit_sum[QWID:0];
`else
   assign start_credit = q_pick;
`endif

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      credit_d  = credit_q;
      burst_end = 1'b0;
`ifdef ARB_DEFICIT_CARRY_EN
      deficit_d = deficit_q;
`endif
      case (state_q)
         ARB_IDLE: begin
            if (pick_found) begin
               state_d  = ARB_SERVE;
               owner_d  = pick_idx;
               credit_d = start_credit;
`ifdef ARB_DEFICIT_CARRY_EN
               deficit_d[pick_idx] = '0;
`endif
            end
         end
         ARB_SERVE: begin
            if (gnt_on) credit_d = credit_q - CW'(1);
            // Last pop and a drained FIFO can coincide; either way the exit happens once.
            if ((gnt_on && credit_q == CW'(1)) || !owner_req) begin
               burst_end = 1'b1;
               state_d   = ARB_IDLE;
               ptr_d     = IDXW'(rr_inc(32'(owner_q), NUM_REQS));
`ifdef ARB_DEFICIT_CARRY_EN
               if (!owner_req) deficit_d[owner_q] = credit_q;
`endif
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ARB_IDLE;
         ptr_q        <= '0;
         owner_q      <= '0;
         credit_q     <= '0;
         burst_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         owner_q      <= owner_d;
         credit_q     <= credit_d;
         burst_done_q <= burst_end;
      end
   end

`ifdef ARB_DEFICIT_CARRY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) deficit_q <= '0;
      else      deficit_q <= deficit_d;
   end
`endif

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      if (gnt_on) begin
         gnt[owner_q] = 1'b1;
         gnt_idx      = owner_q;
      end
   end

   assign gnt_vld    = |gnt;
   assign burst_done = burst_done_q;

endmodule

// File: tb/tb_quantum_rr_arbiter.sv
// Bench for quantum_rr_arbiter: burst-level model compared every cycle, plus
// hand-computed grant/burst_done sequences for each directed scenario.
module tb_quantum_rr_arbiter;

   localparam int N  = 4;
   localparam int QW = 4;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]    reqs     = '0;
   logic [N*QW-1:0] quantums = '0;
   logic [N-1:0]    gnt;
   logic            gnt_vld;
   logic [1:0]      gnt_idx;
   logic            burst_done;

   logic [2:0]      reqs3     = '0;
   logic [11:0]     quantums3 = '0;
   logic [2:0]      gnt3;
   logic            gnt_vld3;
   logic [1:0]      gnt_idx3;
   logic            burst_done3;

   quantum_rr_arbiter #(.NUM_REQS(N), .QWID(QW)) dut (
      .clk        (clk),
      .rst        (rst_n),
      .reqs       (reqs),
      .quantums   (quantums),
      .gnt        (gnt),
      .gnt_vld    (gnt_vld),
      .gnt_idx    (gnt_idx),
      .burst_done (burst_done)
   );

   quantum_rr_arbiter #(.NUM_REQS(3), .QWID(QW)) dut3 (
      .clk        (clk),
      .rst        (rst_n),
      .reqs       (reqs3),
      .quantums   (quantums3),
      .gnt        (gnt3),
      .gnt_vld    (gnt_vld3),
      .gnt_idx    (gnt_idx3),
      .burst_done (burst_done3)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // ---------------- burst-level model ----------------
   bit m_busy;
   bit m_done;
   int m_owner;
   int m_credit;
   int m_ptr;
   int m_def[N];

   always @(posedge clk or negedge rst_n) begin
      int sel, q, c, idx;
      if (!rst_n) begin
         m_busy   <= 1'b0;
         m_done   <= 1'b0;
         m_owner  <= 0;
         m_credit <= 0;
         m_ptr    <= 0;
         for (int i = 0; i < N; i++) m_def[i] <= 0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            sel = -1;
            for (int off = 0; off < N && sel < 0; off++) begin
               idx = (m_ptr + off) % N;
               if (reqs[idx] && quantums[idx*QW +: QW] != 0) sel = idx;
            end
            if (sel >= 0) begin
               q = int'(quantums[sel*QW +: QW]);
`ifdef ARB_DEFICIT_CARRY_EN
               q = q + m_def[sel];
               if (q > 31) q = 31;
               m_def[sel] <= 0;
`endif
               m_busy   <= 1'b1;
               m_owner  <= sel;
               m_credit <= q;
            end
         end else if (!reqs[m_owner]) begin
`ifdef ARB_DEFICIT_CARRY_EN
            m_def[m_owner] <= m_credit;
`endif
            m_busy <= 1'b0;
            m_ptr  <= (m_owner + 1) % N;
            m_done <= 1'b1;
         end else begin
            c = m_credit - 1;
            m_credit <= c;
            if (c == 0) begin
               m_busy <= 1'b0;
               m_ptr  <= (m_owner + 1) % N;
               m_done <= 1'b1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic [3:0] eg;
      eg = (m_busy && reqs[m_owner] && m_credit != 0) ? 4'(1 << m_owner) : 4'd0;
      check("model_gnt", 32'(gnt), 32'(eg));
      check("model_vld", 32'(gnt_vld), 32'(|eg));
      check("model_idx", 32'(gnt_idx), (|eg) ? 32'(m_owner) : 32'd0);
      check("model_done", 32'(burst_done), 32'(m_done));
   end

   // ---------------- driver tasks / scoreboard ----------------
   logic [3:0]  stim_r[$];
   logic [15:0] stim_q[$];
   logic [4:0]  exp_q[$];
   logic [4:0]  got_q[$];

   task automatic do_reset();
      reqs  = '0;
      reqs3 = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One stimulus entry per cycle; samples {burst_done, gnt} mid-cycle.
   task automatic run_stim(input string name);
      got_q.delete();
      for (int i = 0; i < stim_r.size(); i++) begin
         reqs = stim_r[i];
         if (i < stim_q.size()) quantums = stim_q[i];
         @(negedge clk);
         got_q.push_back({burst_done, gnt});
         @(posedge clk);
         #1;
      end
      check({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_c%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   initial begin
      #1;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_vld", 32'(gnt_vld), 32'd0);
      check("rst_idx", 32'(gnt_idx), 32'd0);
      check("rst_done", 32'(burst_done), 32'd0);

      // Quantum burst and rotation
      do_reset();
      stim_r = '{4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3};
      stim_q = '{16'h0023};
      exp_q  = '{5'h00, 5'h01, 5'h01, 5'h01, 5'h10, 5'h02, 5'h02, 5'h10, 5'h01, 5'h01, 5'h01};
      run_stim("rotate");

      // Early drain, then rotation from ptr=3
      do_reset();
      stim_q = '{16'h1500};
`ifdef ARB_DEFICIT_CARRY_EN
      stim_r = '{4'h4, 4'h4, 4'h4, 4'h0, 4'hC, 4'hC, 4'hC, 4'hC, 4'hC, 4'hC, 4'hC, 4'hC,
                 4'hC, 4'hC, 4'hC, 4'hC};
      exp_q  = '{5'h00, 5'h04, 5'h04, 5'h00, 5'h10, 5'h08, 5'h10, 5'h04, 5'h04, 5'h04,
                 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h10};
`else
      stim_r = '{4'h4, 4'h4, 4'h4, 4'h0, 4'hC, 4'hC, 4'hC, 4'hC, 4'hC, 4'hC, 4'hC, 4'hC,
                 4'hC, 4'hC};
      exp_q  = '{5'h00, 5'h04, 5'h04, 5'h00, 5'h10, 5'h08, 5'h10, 5'h04, 5'h04, 5'h04,
                 5'h04, 5'h04, 5'h10, 5'h08};
`endif
      run_stim("drain");

      // Skip disabled requester and wrap
      do_reset();
      stim_r = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
      stim_q = '{16'h0111};
      exp_q  = '{5'h00, 5'h01, 5'h10, 5'h02, 5'h10, 5'h04, 5'h10, 5'h01, 5'h10, 5'h02,
                 5'h10, 5'h04};
      run_stim("skip");

      // Quantum change mid-burst only affects the next burst
      do_reset();
      stim_r = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2};
      stim_q = '{16'h0040, 16'h0010};
      exp_q  = '{5'h00, 5'h02, 5'h02, 5'h02, 5'h02, 5'h10, 5'h02, 5'h10, 5'h02};
      run_stim("qchange");

      // Asynchronous reset during the second pop of a burst
      do_reset();
      stim_r = '{4'h1, 4'h1};
      stim_q = '{16'h3333};
      exp_q  = '{5'h00, 5'h01};
      run_stim("rst_pre");
      check("rst_mid_before", 32'(gnt), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_gnt", 32'(gnt), 32'd0);
      check("rst_mid_vld", 32'(gnt_vld), 32'd0);
      check("rst_mid_done", 32'(burst_done), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      stim_r = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
      exp_q  = '{5'h00, 5'h01, 5'h01, 5'h01, 5'h10};
      run_stim("rst_post");

      // Three requesters: lone requester 2 with quantum 1
      do_reset();
      quantums3 = 12'h100;
      reqs3     = 3'b100;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("n3_gnt_c%0d", i), 32'(gnt3), (i % 2 == 1) ? 32'h4 : 32'h0);
         check($sformatf("n3_idx_c%0d", i), 32'(gnt_idx3), (i % 2 == 1) ? 32'd2 : 32'd0);
         check($sformatf("n3_vld_c%0d", i), 32'(gnt_vld3), (i % 2 == 1) ? 32'd1 : 32'd0);
         check($sformatf("n3_done_c%0d", i), 32'(burst_done3),
               (i >= 2 && i % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("n3_known_c%0d", i),
               32'($isunknown({gnt3, gnt_idx3, gnt_vld3, burst_done3})), 32'd0);
         @(posedge clk);
         #1;
      end
      reqs3 = '0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/quantum_rr_arbiter.md
Name: quantum_rr_arbiter

Overview:
- Quantum-weighted round-robin arbiter that drives the per-FIFO pop/grant vector of the arbitrated FIFO bank.
- Requester i is a non-empty FIFO. When it wins, it may pop up to quantums[i] words back-to-back. The grant then rotates to the next requester.
- Sits between the FIFO bank's empty flags and the pop inputs. Its gnt output feeds both the FIFO pops and the scoreboard pop.

Parameters:
- NUM_REQS, 4, number of requesters (>=2; need not be a power of 2).
- QWID, 4, width of each quantum field.
- IDXW, $clog2(NUM_REQS), localparam, width of the requester index.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- reqs  input  NUM_REQS  request per requester (FIFO not empty).
- quantums  input  NUM_REQS*QWID  packed quantum per requester; field i = [(i+1)*QWID-1 : i*QWID].
- gnt  output  NUM_REQS  one-hot-or-zero pop grant.
- gnt_vld  output  1  =|gnt.
- gnt_idx  output  IDXW  owner index; valid when gnt_vld=1.
- burst_done  output  1  registered one-cycle pulse in the cycle after a burst ends.

Behaviour:
- Reset (rst=0, async), all cleared:
  - state=ARB_IDLE, ptr=0, owner=0, credit=0, burst_done=0.
  - gnt, gnt_vld and gnt_idx read 0.
- Assertion of rst mid-burst aborts the burst immediately. Credit is lost.
- State ARB_IDLE:
  - A combinational rotating search starts at ptr, wrapping from NUM_REQS-1 to 0.
  - It selects the first i with reqs[i]=1 and quantums[i]!=0.
  - If found, at the next edge: owner<=i, credit<=quantums[i], state<=ARB_SERVE.
  - If none is found, stay in ARB_IDLE.
  - gnt=0 throughout ARB_IDLE.
- State ARB_SERVE:
  - gnt[owner] = reqs[owner] && (credit!=0). gnt is combinational from registered state and the current reqs.
  - Each cycle gnt is high, credit decrements by 1 at the edge.
  - Exit to ARB_IDLE, with ptr <= (owner+1) mod NUM_REQS and a burst_done pulse next cycle, when either:
    - gnt is high and credit==1 (last pop), or
    - reqs[owner]==0 (the FIFO drained).
- Latency:
  - One ARB_IDLE bubble cycle between bursts.
  - First gnt is exactly 1 cycle after a request is seen in ARB_IDLE.
- Quantum handling:
  - Quantum is sampled only at burst start; changes mid-burst are ignored.
  - quantums[i]==0 means requester i is skipped (disabled).
- Simultaneous events:
  - reqs[owner] dropping in the same cycle as the last credit gives a single exit. ptr advances once.
  - A new request arriving while another is served waits for rotation. No preemption.
- A lone requester is re-granted after each bubble, so steady-state throughput is q/(q+1).

Optional Feature:
- Macro: ARB_DEFICIT_CARRY_EN.
- Defined:
  - Keep a per-requester deficit register, width QWID+1.
  - On exit with credit remaining because reqs[owner]==0, deficit[owner] <= credit.
  - On burst start, credit <= quantums[i] + deficit[i], saturating at 2^(QWID+1)-1, and deficit[i] <= 0.
  - Deficit registers reset to 0.
  - A requester with quantum 0 but nonzero deficit is still skipped.
- Undefined:
  - No deficit storage; leftover credit is discarded.
  - credit width is QWID.

Decomposition:
- Package arb_pkg:
  - typedef enum arb_state_t {ARB_IDLE, ARB_SERVE}.
  - Function for rotating index increment mod NUM_REQS.
- Sub-module rr_pick: combinational rotating-priority encoder.
  - Inputs: eligible vector, ptr.
  - Outputs: found, idx.

Test Plan:
- Reset mid-burst: N=4, quantums all 3, reqs=4'b0001; assert rst during 2nd gnt -> gnt=0 asynchronously; after release, first gnt[0] 2 cycles later with a full 3 credits.
- Quantum burst and rotation: reqs=4'b0011 held, quantums={_,_,2,3} -> gnt pattern: 0001 x3, idle, 0010 x2, idle, 0001 x3; burst_done pulses after each burst.
- Early drain: quantum[2]=5, reqs[2] drops after 2 pops -> exactly 2 gnts, exit, ptr=3. With ARB_DEFICIT_CARRY_EN, next burst for 2 gives 5+3=8 gnts if reqs stays high.
- Skip and wrap: quantums={0,1,1,1}, reqs=4'b1111, ptr starts 0 -> grant order 0,1,2,0,1,2; requester 3 never granted.
- Mid-burst quantum change: quantum[1] changes 4->1 during 1's burst -> current burst still 4 gnts; next burst for 1 is 1 gnt.
- Non-power-of-2 (N=3): reqs=3'b100 only, quantum 1 -> gnt_idx=2 every other cycle; ptr wraps to 0 without X.
